ssd_display_driver: RTL and testbench

//   Consumer of the processor's 13-bit ssd output. Converts the unsigned binary value
//   to 4 BCD digits with a sequential double-dabble FSM, then time-multiplexes them

---
 rtl/ssd_display_driver_if.sv | 20 ++
 rtl/ssd_display_driver.sv | 148 ++++++++++++++
 tb/tb_ssd_display_driver.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_display_driver_if.sv
// Bundle of the value/display signals between the processor wrapper and the display driver.
// Member names match the driver's port names so wrappers can connect them one-to-one.
interface ssd_display_driver_if;
    logic [12:0] value;
    logic [15:0] bcd;
    logic        busy;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output value,
        input  bcd, busy, anode, seg, dp
    );

    modport slave (
        input  value,
        output bcd, busy, anode, seg, dp
    );
endinterface

// File: rtl/ssd_display_driver.sv
// Binary-to-BCD (sequential double-dabble) converter feeding a scanned 4-digit
// common-anode seven-segment display.
module ssd_display_driver #(
    parameter int unsigned REFRESH_BITS = 18,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] value,
    output logic [15:0] bcd,
    output logic        busy,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [15:0]             r_acc;
    logic [15:0]             r_bcd;
    logic [12:0]             r_bin;
    logic [12:0]             r_latch;
    logic [12:0]             r_shown;
    logic [3:0]              r_iter;
    logic [REFRESH_BITS-1:0] r_cnt;
    logic [3:0]              r_anode;
    logic [6:0]              r_seg;

    logic        w_start;
    logic        w_done;
    logic        w_busy;
    logic [15:0] w_adj;
    logic [1:0]  w_idx;
    logic [3:0]  w_digit;
    logic        w_blank;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (value != r_shown) w_next = S_CONV;
            S_CONV:  if (r_iter == 4'd13)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs; iter 0..12 are the 13 shift cycles, iter 13 commits the result
    always_comb begin
        w_start = (r_state == S_IDLE) && (value != r_shown);
        w_done  = (r_state == S_CONV) && (r_iter == 4'd13);
        w_busy  = (r_state == S_CONV);
    end

    always_comb begin
        w_adj = r_acc;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_acc[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_bin   <= '0;
            r_latch <= '0;
            r_shown <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
        end else if (w_start) begin
            r_bin   <= value;
            r_latch <= value;
            r_acc   <= '0;
            r_iter  <= '0;
        end else if (w_done) begin
            r_bcd   <= r_acc;
            r_shown <= r_latch;
        end else if (w_busy) begin
            r_acc  <= {w_adj[14:0], r_bin[12]};
            r_bin  <= {r_bin[11:0], 1'b0};
            r_iter <= r_iter + 4'd1;
        end
    end

    always_comb begin
        w_idx = r_cnt[REFRESH_BITS-1 -: 2];
        case (w_idx)
            2'd0:    w_digit = r_bcd[3:0];
            2'd1:    w_digit = r_bcd[7:4];
            2'd2:    w_digit = r_bcd[11:8];
            default: w_digit = r_bcd[15:12];
        endcase
        // a digit is a leading zero only if it and every higher digit are zero
        case (w_idx)
            2'd0:    w_blank = 1'b0;
            2'd1:    w_blank = BLANK_LZ && (r_bcd[15:4] == 12'd0);
            2'd2:    w_blank = BLANK_LZ && (r_bcd[15:8] == 8'd0);
            default: w_blank = BLANK_LZ && (r_bcd[15:12] == 4'd0);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_anode <= 4'b1111;
            r_seg   <= 7'h7F;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_blank) begin
                r_anode <= 4'b1111;
                r_seg   <= 7'h7F;
            end else begin
                r_anode <= ~(4'b0001 << w_idx);
                r_seg   <= seg_of(w_digit);
            end
        end
    end

    assign bcd   = r_bcd;
    assign busy  = w_busy;
    assign anode = r_anode;
    assign seg   = r_seg;
    assign dp    = 1'b1;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Scoreboard bench for ssd_display_driver: one instance with leading-zero blanking, one without.
module tb_ssd_display_driver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ssd_display_driver_if bus_b ();
    ssd_display_driver_if bus_n ();

    ssd_display_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .reset(reset), .value(bus_b.value), .bcd(bus_b.bcd), .busy(bus_b.busy),
        .anode(bus_b.anode), .seg(bus_b.seg), .dp(bus_b.dp)
    );

    ssd_display_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .value(bus_n.value), .bcd(bus_n.bcd), .busy(bus_n.busy),
        .anode(bus_n.anode), .seg(bus_n.seg), .dp(bus_n.dp)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_bcd = 16'h0000;

    function automatic logic [15:0] ref_bcd(input int v);
        ref_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: ref_seg = 7'b1000000;  4'd1: ref_seg = 7'b1111001;
            4'd2: ref_seg = 7'b0100100;  4'd3: ref_seg = 7'b0110000;
            4'd4: ref_seg = 7'b0011001;  4'd5: ref_seg = 7'b0010010;
            4'd6: ref_seg = 7'b0000010;  4'd7: ref_seg = 7'b1111000;
            4'd8: ref_seg = 7'b0000000;  4'd9: ref_seg = 7'b0010000;
            default: ref_seg = 7'h7F;
        endcase
    endfunction

    function automatic bit ref_blank(input int slot, input logic [15:0] b, input bit blz);
        bit z = 1'b1;
        for (int k = slot; k < 4; k++) if (b[k*4 +: 4] != 4'd0) z = 1'b0;
        ref_blank = blz && (slot != 0) && z;
    endfunction

    task automatic drive_value(input int v);
        @(negedge clk);
        bus_b.value = v[12:0];
        bus_n.value = v[12:0];
        exp_q.push_back(ref_bcd(v));
    endtask

    task automatic wait_conversion(input string name, input bit check_len);
        int          win = 0;
        logic [15:0] exp;
        for (int i = 0; i < 20 && !bus_b.busy; i++) @(negedge clk);
        if (!bus_b.busy) begin
            checks++; errors++;
            $display("FAIL %s busy_rise: busy never rose within 20 cycles", name);
        end else begin
            while (bus_b.busy && win < 40) begin
                win++;
                checks++;
                if (bus_b.bcd !== last_bcd) begin
                    errors++;
                    $display("FAIL %s bcd_hold: got %h expected %h", name, bus_b.bcd, last_bcd);
                end
                @(negedge clk);
            end
            if (check_len) begin
                checks++;
                if (win !== 14) begin
                    errors++;
                    $display("FAIL %s busy_len: got %0d expected 14", name, win);
                end
            end
        end
        exp = exp_q.pop_front();
        checks++;
        if (bus_b.bcd !== exp) begin
            errors++;
            $display("FAIL %s bcd: got %h expected %h", name, bus_b.bcd, exp);
        end
        checks++;
        if (bus_n.bcd !== exp) begin
            errors++;
            $display("FAIL %s bcd_nb: got %h expected %h", name, bus_n.bcd, exp);
        end
        last_bcd = exp;
    endtask

    task automatic scan_check(input bit nb, input logic [15:0] b, input string name);
        int          hits[4] = '{0, 0, 0, 0};
        logic [3:0]  a;
        logic [6:0]  s;
        logic [3:0]  one = 4'b0001;
        int          slot;
        bit          blz = !nb;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            a = nb ? bus_n.anode : bus_b.anode;
            s = nb ? bus_n.seg : bus_b.seg;
            slot = -1;
            for (int k = 0; k < 4; k++) if (a == ~(one << k)) slot = k;
            checks++;
            if (a == 4'b1111) begin
                if (s !== 7'h7F) begin
                    errors++;
                    $display("FAIL %s blank_seg: got %b expected %b", name, s, 7'h7F);
                end
            end else if (slot < 0) begin
                errors++;
                $display("FAIL %s anode: got %b expected one active-low slot", name, a);
            end else begin
                hits[slot]++;
                if (s !== ref_seg(b[slot*4 +: 4])) begin
                    errors++;
                    $display("FAIL %s seg_slot%0d: got %b expected %b", name, slot, s,
                             ref_seg(b[slot*4 +: 4]));
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (hits[k] !== (ref_blank(k, b, blz) ? 0 : 4)) begin
                errors++;
                $display("FAIL %s slot%0d_cycles: got %0d expected %0d", name, k, hits[k],
                         ref_blank(k, b, blz) ? 0 : 4);
            end
        end
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (bus_b.bcd !== 16'h0000 || bus_b.busy !== 1'b0 || bus_b.anode !== 4'b1111 ||
            bus_b.seg !== 7'h7F || bus_b.dp !== 1'b1) begin
            errors++;
            $display("FAIL %s: got bcd=%h busy=%b anode=%b seg=%b dp=%b expected 0000 0 1111 1111111 1",
                     name, bus_b.bcd, bus_b.busy, bus_b.anode, bus_b.seg, bus_b.dp);
        end
        checks++;
        if (bus_n.bcd !== 16'h0000 || bus_n.busy !== 1'b0 || bus_n.anode !== 4'b1111) begin
            errors++;
            $display("FAIL %s_nb: got bcd=%h busy=%b anode=%b expected 0000 0 1111",
                     name, bus_n.bcd, bus_n.busy, bus_n.anode);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_b.value = 13'd0;
        bus_n.value = 13'd0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (bus_b.busy !== 1'b0 || bus_b.bcd !== 16'h0000) begin
                errors++;
                $display("FAIL reset_idle: got busy=%b bcd=%h expected 0 0000", bus_b.busy, bus_b.bcd);
            end
        end
        scan_check(1'b0, 16'h0000, "reset_scan");
    endtask

    task automatic test_max();
        drive_value(8191);
        wait_conversion("max", 1'b1);
        scan_check(1'b0, 16'h8191, "max_scan");
        scan_check(1'b1, 16'h8191, "max_scan_nb");
    endtask

    task automatic test_blanking();
        drive_value(42);
        wait_conversion("blank42", 1'b1);
        scan_check(1'b0, 16'h0042, "blank42_scan");
        scan_check(1'b1, 16'h0042, "blank42_scan_nb");
        drive_value(7);
        wait_conversion("blank7", 1'b1);
        scan_check(1'b0, 16'h0007, "blank7_scan");
        drive_value(1005);
        wait_conversion("blank1005", 1'b1);
        scan_check(1'b0, 16'h1005, "blank1005_scan");
    endtask

    task automatic test_back_to_back();
        drive_value(100);
        for (int i = 0; i < 20 && !bus_b.busy; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        bus_b.value = 13'd200;
        bus_n.value = 13'd200;
        exp_q.push_back(ref_bcd(200));
        wait_conversion("b2b_first", 1'b0);
        @(negedge clk);
        checks++;
        if (bus_b.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b expected 1 after one idle cycle", bus_b.busy);
        end
        wait_conversion("b2b_second", 1'b1);
    endtask

    task automatic test_reset_abort();
        drive_value(1234);
        for (int i = 0; i < 20 && !bus_b.busy; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("abort");
        reset = 1'b0;
        last_bcd = 16'h0000;
        wait_conversion("abort_reconv", 1'b1);
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 8192; v += 7) begin
            drive_value(v);
            wait_conversion("sweep", 1'b1);
        end
        drive_value(8191);
        wait_conversion("sweep_max", 1'b1);
    endtask

    initial begin
        test_reset();
        test_max();
        test_blanking();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
